ripple_count_capture: RTL and testbench
=======================================

Name: ripple_count_capture

Overview:
- Downstream consumer of the 4-bit asynchronous ripple counter.
- Brings the ripple count bus into the `clk` domain through a 2-flop synchronizer.
- Filters ripple-transition glitches by requiring STABLE_CYCLES identical consecutive samples.
- Extends the count with a wrap-tracking upper field and returns snapshots through a valid/ready handshake.

Parameters:
- WIDTH, 4, width of the ripple count input.
- EXT_WIDTH, 4, width of the wrap-extension field; the snapshot is WIDTH+EXT_WIDTH bits.
- STABLE_CYCLES, 2, consecutive identical synchronized samples needed to accept a value (range 1..15).
- TIMEOUT_CYCLES, 64, maximum WAIT_STABLE dwell; used only with CAPTURE_TIMEOUT_EN (range 1..255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- count_in  input  WIDTH  raw ripple counter outputs (asynchronous to clk).
- capture_req  input  1  single-cycle request for a snapshot.
- snap_ready  input  1  consumer accepts the snapshot.
- snap_valid  output  1  snapshot available.
- snap_data  output  WIDTH+EXT_WIDTH  {ext_cnt, settled_val}.
- snap_err  output  1  snapshot was taken on timeout, not on a settled value.
- wrap_pulse  output  1  one-cycle pulse on each detected wrap.
- busy  output  1  FSM is not IDLE.

Behaviour:
- Reset is asynchronous on rst_n low. All of the following go to 0:
  - sync flops, sample history, stable counter (s_cnt), settled_val, ext_cnt
  - snap_data, snap_valid, snap_err, wrap_pulse, busy, timeout counter
- FSM resets to IDLE.
- Reset asserted mid-handshake discards the pending snapshot.
- Synchronizer:
  - sync1 <= count_in, then sync2 <= sync1; sync_prev <= sync2.
- Stable filter:
  - If sync2 != sync_prev, s_cnt <= 0.
  - Otherwise s_cnt increments, saturating at STABLE_CYCLES.
  - stable = (s_cnt == STABLE_CYCLES).
- Settled update: on a cycle where stable=1 and sync2 != settled_val, settled_val <= sync2 (one update per settled value).
  - Latency from a clean count_in change to the settled_val update is 3+STABLE_CYCLES clk cycles.
- Wrap detect:
  - On a settled update where the new value is less than the old settled_val (unsigned), ext_cnt <= ext_cnt+1 mod 2^EXT_WIDTH.
  - wrap_pulse is high for exactly that cycle.
  - Multiple wraps between settled updates are not detectable. The input count rate must stay below clk/(2*(STABLE_CYCLES+3)).
- FSM states: IDLE, WAIT_STABLE, HOLD.
  - IDLE: capture_req=1 -> WAIT_STABLE, timeout counter cleared.
  - WAIT_STABLE, when stable=1 and no settled update is pending this cycle:
    - snap_data <= {ext_cnt, settled_val}
    - snap_valid <= 1, snap_err <= 0
    - go to HOLD
  - WAIT_STABLE, when an update occurs that same cycle: capture the post-update values (next cycle).
  - HOLD: snap_valid stays 1 and snap_data/snap_err stay frozen until snap_ready=1. On that cycle, snap_valid <= 0 next cycle and the FSM returns to IDLE.
- capture_req outside IDLE is ignored (not queued). capture_req coinciding with a snap_ready acceptance is also ignored.
- busy = (state != IDLE).
- The filter, settled update and wrap tracking run continuously in every FSM state, including HOLD. Only the snapshot register freezes.
- ext_cnt wraps silently from 2^EXT_WIDTH-1 to 0.

Optional Feature:
- Macro: CAPTURE_TIMEOUT_EN.
- Defined:
  - The timeout counter counts cycles spent in WAIT_STABLE.
  - When it reaches TIMEOUT_CYCLES without a capture: snap_data <= {ext_cnt, settled_val} (last good value), snap_err <= 1, snap_valid <= 1, go to HOLD.
- Undefined:
  - No timeout logic; snap_err is tied to 0.
  - WAIT_STABLE waits indefinitely for stability.

Test Plan:
- Reset: assert rst_n=0 mid-HOLD with snap_valid=1 -> all outputs 0 asynchronously (before the next clk edge); state IDLE after release.
- Settled capture:
  - Stimulus: count_in held at 4'h5 for 20 cycles, then capture_req pulse.
  - Required: snap_valid rises and snap_data=8'h05, snap_err=0.
  - Required: snap_data is held while snap_ready=0 for 10 cycles; snap_valid drops the cycle after snap_ready=1.
- Glitch rejection (STABLE_CYCLES=2):
  - Stimulus: count_in 4'h7 -> 4'h6 for 1 cycle -> 4'h4 -> 4'h0 for 1 cycle -> 4'h8 held (ripple of 7->8).
  - Required: settled_val goes directly 7->8; no capture or settled value of 6, 4 or 0; no wrap_pulse.
- Wrap:
  - Stimulus: step count_in 4'hE, 4'hF, 4'h0, 4'h1, each held 10 cycles.
  - Required: exactly one wrap_pulse on the 0 update; a subsequent capture gives snap_data=8'h11.
- Extension rollover: 16 full 0..F sweeps -> ext_cnt returns to 0; exactly 16 wrap_pulses counted.
- Timeout (CAPTURE_TIMEOUT_EN, TIMEOUT_CYCLES=64):
  - Stimulus: toggle count_in bit 0 every cycle after settled_val=4'h3, then capture_req.
  - Required: snap_valid rises 64 cycles into WAIT_STABLE with snap_err=1 and snap_data=8'h03.
  - Without the macro: busy stays 1 and snap_valid stays 0.

Source files
------------

// File: rtl/ripple_count_capture.sv
// Synchronizes, glitch-filters and wrap-extends a 4-bit ripple counter; hands out snapshots over valid/ready.
// Optional build macro CAPTURE_TIMEOUT_EN: bounded WAIT_STABLE dwell that returns the last good value flagged by snap_err.
module ripple_count_capture #(
  parameter int WIDTH          = 4,
  parameter int EXT_WIDTH      = 4,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       capture_req,
  input  logic                       snap_ready,
  output logic                       snap_valid,
  output logic [WIDTH+EXT_WIDTH-1:0] snap_data,
  output logic                       snap_err,
  output logic                       wrap_pulse,
  output logic                       busy
);

  localparam logic [3:0]           STABLE_MAX = 4'(STABLE_CYCLES);
  localparam logic [EXT_WIDTH-1:0] EXT_ONE    = EXT_WIDTH'(1);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15) begin : g_bad_stable
    $error("STABLE_CYCLES must be within 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [1:0] {IDLE, WAIT_STABLE, HOLD} state_t;

  state_t               state;
  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  logic [WIDTH-1:0]     sync_prev;
  logic [WIDTH-1:0]     settled_val;
  logic [3:0]           s_cnt;
  logic [EXT_WIDTH-1:0] ext_cnt;
  logic                 stable;
  logic                 upd;
  logic                 wrap;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STABLE_MAX) ? STABLE_MAX : v + 4'd1;
  endfunction

  // Stage: two-flop synchronizer plus one-sample history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= count_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // Stage: stability filter; a sample that differs from its predecessor is never trusted,
  // even if the counter is still saturated from the previous value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt <= '0;
    end else if (sync2 != sync_prev) begin
      s_cnt <= '0;
    end else begin
      s_cnt <= sat_inc(s_cnt);
    end
  end

  assign stable = (s_cnt == STABLE_MAX) && (sync2 == sync_prev);
  assign upd    = stable && (sync2 != settled_val);
  assign wrap   = upd && (sync2 < settled_val);

  // Stage: settled value and wrap extension
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settled_val <= '0;
      ext_cnt     <= '0;
      wrap_pulse  <= 1'b0;
    end else begin
      wrap_pulse <= wrap;
      if (upd) begin
        settled_val <= sync2;
      end
      if (wrap) begin
        ext_cnt <= ext_cnt + EXT_ONE;
      end
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;
`else
  assign snap_err = 1'b0;
`endif

  // Stage: snapshot FSM; the snapshot register is the only state frozen in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap_valid <= 1'b0;
      snap_data  <= '0;
`ifdef CAPTURE_TIMEOUT_EN
      snap_err   <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (capture_req) begin
            state <= WAIT_STABLE;
`ifdef CAPTURE_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        WAIT_STABLE: begin
          // An update this cycle defers the capture so the post-update value is returned
          if (stable && !upd) begin
            snap_data  <= {ext_cnt, settled_val};
            snap_valid <= 1'b1;
            state      <= HOLD;
`ifdef CAPTURE_TIMEOUT_EN
            snap_err   <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            snap_data  <= {ext_cnt, settled_val};
            snap_valid <= 1'b1;
            snap_err   <= 1'b1;
            state      <= HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
`endif
          end
        end
        HOLD: begin
          if (snap_ready) begin
            snap_valid <= 1'b0;
            state      <= IDLE;
`ifdef CAPTURE_TIMEOUT_EN
            snap_err   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ripple_count_capture.sv
// Randomized bench for ripple_count_capture against a value-level model of settled count and wrap extension.
module tb_ripple_count_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] count_in = 4'h0;
  logic       capture_req = 1'b0;
  logic       snap_ready = 1'b0;
  logic       snap_valid;
  logic [7:0] snap_data;
  logic       snap_err;
  logic       wrap_pulse;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int seen_wraps = 0;
  int m_wraps = 0;
  logic [3:0] m_settled = 4'h0;
  logic [3:0] m_ext = 4'h0;

  ripple_count_capture #(
    .WIDTH(4), .EXT_WIDTH(4), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .capture_req(capture_req),
    .snap_ready(snap_ready), .snap_valid(snap_valid), .snap_data(snap_data),
    .snap_err(snap_err), .wrap_pulse(wrap_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && wrap_pulse) seen_wraps++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  // A value held long enough becomes the settled value; a decrease counts as one wrap.
  function automatic void model_step(input logic [3:0] v);
    if (v != m_settled) begin
      if (v < m_settled) begin
        m_ext   = m_ext + 4'd1;
        m_wraps = m_wraps + 1;
      end
      m_settled = v;
    end
  endfunction

  task automatic hold_value(input logic [3:0] v, input int n);
    count_in = v;
    repeat (n) @(negedge clk);
    model_step(v);
  endtask

  task automatic glitch(input logic [3:0] v);
    count_in = v;
    @(negedge clk);
  endtask

  task automatic do_capture(input string name, input logic [3:0] hold_v);
    logic [7:0] exp;
    int n;
    exp = {m_ext, m_settled};
    capture_req = 1'b1;
    @(negedge clk);
    capture_req = 1'b0;
    n = 0;
    while (!snap_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (snap_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: snap_valid=%b after %0d cycles, expected 1", name, snap_valid, n);
    end
    checks++;
    if (snap_data !== exp) begin
      errors++;
      $display("FAIL %s_data: snap_data=%h, expected %h", name, snap_data, exp);
    end
    checks++;
    if (snap_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_err: snap_err=%b, expected 0", name, snap_err);
    end
    count_in = hold_v;
    for (int i = 0; i < 10; i++) begin
      capture_req = (i == 3);
      @(negedge clk);
      checks++;
      if (snap_valid !== 1'b1 || snap_data !== exp) begin
        errors++;
        $display("FAIL %s_hold: cycle %0d valid=%b data=%h, expected 1 %h", name, i, snap_valid, snap_data, exp);
      end
    end
    model_step(hold_v);
    capture_req = 1'b1;
    snap_ready  = 1'b1;
    @(negedge clk);
    capture_req = 1'b0;
    snap_ready  = 1'b0;
    checks++;
    if (snap_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: valid=%b busy=%b, expected 0 0", name, snap_valid, busy);
    end
  endtask

  task automatic test_reset;
    int n;
    checks++;
    if ({snap_valid, snap_data, snap_err, wrap_pulse, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_initial: valid=%b data=%h err=%b wrap=%b busy=%b, expected all 0",
               snap_valid, snap_data, snap_err, wrap_pulse, busy);
    end
    rst_n = 1'b1;
    hold_value(4'h3, 12);
    capture_req = 1'b1;
    @(negedge clk);
    capture_req = 1'b0;
    n = 0;
    while (!snap_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (snap_valid !== 1'b1 || snap_data !== 8'h03) begin
      errors++;
      $display("FAIL reset_prehold: valid=%b data=%h, expected 1 03", snap_valid, snap_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({snap_valid, snap_data, snap_err, wrap_pulse, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_async: valid=%b data=%h err=%b wrap=%b busy=%b, expected all 0",
               snap_valid, snap_data, snap_err, wrap_pulse, busy);
    end
    @(negedge clk);
    count_in  = 4'h0;
    m_settled = 4'h0;
    m_ext     = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || snap_valid !== 1'b0 || snap_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: busy=%b valid=%b data=%h, expected 0 0 00", busy, snap_valid, snap_data);
    end
  endtask

  task automatic test_settled;
    hold_value(4'h5, 20);
    checks++;
    if ({m_ext, m_settled} !== 8'h05) begin
      errors++;
      $display("FAIL settled_model: model=%h, expected 05", {m_ext, m_settled});
    end
    do_capture("settled", 4'h9);
    do_capture("settled_in_hold", 4'h9);
  endtask

  task automatic test_glitch;
    int w0;
    hold_value(4'h7, 12);
    w0 = seen_wraps;
    glitch(4'h6);
    glitch(4'h4);
    glitch(4'h0);
    hold_value(4'h8, 12);
    checks++;
    if (seen_wraps !== w0) begin
      errors++;
      $display("FAIL glitch_wrap: wrap pulses=%0d, expected 0", seen_wraps - w0);
    end
    do_capture("glitch", 4'h8);
  endtask

  task automatic test_wrap;
    int w0;
    w0 = seen_wraps;
    hold_value(4'hE, 10);
    hold_value(4'hF, 10);
    hold_value(4'h0, 10);
    hold_value(4'h1, 10);
    checks++;
    if (seen_wraps - w0 !== 1) begin
      errors++;
      $display("FAIL wrap_count: wrap pulses=%0d, expected 1", seen_wraps - w0);
    end
    do_capture("wrap", 4'h1);
  endtask

  task automatic test_rollover;
    int w0;
    w0 = seen_wraps;
    for (int s = 0; s < 16; s++)
      for (int v = 0; v < 16; v++)
        hold_value(4'(v), 10);
    checks++;
    if (seen_wraps - w0 !== 16) begin
      errors++;
      $display("FAIL rollover_count: wrap pulses=%0d, expected 16", seen_wraps - w0);
    end
    do_capture("rollover", 4'hF);
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 2) == 0) glitch(4'($urandom_range(0, 15)));
        hold_value(4'($urandom_range(0, 15)), $urandom_range(10, 16));
      end
      do_capture("random", m_settled);
    end
  endtask

  task automatic test_timeout;
    int n;
    hold_value(4'h3, 12);
    repeat (4) begin
      count_in = count_in ^ 4'd1;
      @(negedge clk);
    end
    capture_req = 1'b1;
    count_in = count_in ^ 4'd1;
    @(negedge clk);
    capture_req = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
    n = 1;
    while (!snap_valid && n < 200) begin
      count_in = count_in ^ 4'd1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 65) begin
      errors++;
      $display("FAIL timeout_latency: valid at cycle %0d, expected 65", n);
    end
    checks++;
    if (snap_valid !== 1'b1 || snap_err !== 1'b1 || snap_data !== {m_ext, 4'h3}) begin
      errors++;
      $display("FAIL timeout_snap: valid=%b err=%b data=%h, expected 1 1 %h",
               snap_valid, snap_err, snap_data, {m_ext, 4'h3});
    end
    count_in = 4'h3;
    repeat (3) @(negedge clk);
    snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
    checks++;
    if (snap_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_accept: valid=%b busy=%b, expected 0 0", snap_valid, busy);
    end
    repeat (10) @(negedge clk);
`else
    for (int i = 0; i < 100; i++) begin
      count_in = count_in ^ 4'd1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || snap_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait: cycle %0d busy=%b valid=%b, expected 1 0", i, busy, snap_valid);
      end
    end
    count_in = 4'h3;
    n = 0;
    while (!snap_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (snap_valid !== 1'b1 || snap_err !== 1'b0 || snap_data !== {m_ext, 4'h3}) begin
      errors++;
      $display("FAIL timeout_recover: valid=%b err=%b data=%h, expected 1 0 %h",
               snap_valid, snap_err, snap_data, {m_ext, 4'h3});
    end
    snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
    checks++;
    if (snap_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_accept: valid=%b busy=%b, expected 0 0", snap_valid, busy);
    end
`endif
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_settled();
    test_glitch();
    test_wrap();
    test_rollover();
    test_random();
    test_timeout();
    repeat (5) @(negedge clk);
    checks++;
    if (seen_wraps !== m_wraps) begin
      errors++;
      $display("FAIL wrap_total: wrap pulses=%0d, expected %0d", seen_wraps, m_wraps);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
